inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 Parameter: NOP_INST, default 32'h00000013, instruction presented to decode while the queue is empty.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all queued entries (branch/jump redirect).
REQ-006 in_valid  input  1  fetch stage presents an instruction this cycle.
REQ-007 in_pc  input  32  PC of the presented instruction.
REQ-008 in_inst  input  32  presented instruction word.
REQ-009 in_ready  output  1  queue accepts a push this cycle.
REQ-010 out_valid  output  1  head entry holds a real instruction.
REQ-011 out_pc  output  32  PC of head entry.
REQ-012 out_inst  output  32  head instruction word; bits [31:7] feed the immediate extender.
REQ-013 out_ready  input  1  decode consumes the head this cycle (low = decode stall/bubble).
REQ-014 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Push occurs when in_valid && in_ready && !flush; entry written at tail, tail pointer increments modulo DEPTH.
REQ-016 Pop occurs when out_valid && out_ready && !flush; head pointer increments modulo DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH), independent of out_ready (no combinational ready path through the queue).
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 First-word fall-through: out_pc/out_inst driven combinationally from the head storage entry; an entry pushed at edge N is visible at the outputs after edge N and poppable in that same cycle.
REQ-020 No same-cycle bypass: when empty, a push does not appear on the outputs in the cycle it is presented.
REQ-021 When count == 0: out_inst = NOP_INST, out_pc = 32'h0, regardless of storage contents.
REQ-022 Simultaneous push and pop: both pointers advance, count unchanged; legal at any count 1..DEPTH-1, and at count == DEPTH only the pop happens (in_ready low).
REQ-023 count updates: +1 push only, -1 pop only, unchanged both/neither; never exceeds DEPTH nor goes below 0.
REQ-024 Pointers wrap from DEPTH-1 to 0 with no loss of ordering; entries leave in strict push order.
REQ-025 in_valid while in_ready is low: instruction not stored; fetch holds it (no drop, no error state).
REQ-026 flush: at next edge head = tail = 0, count = 0; concurrent push and pop in the flush cycle are ignored.
REQ-027 flush while empty is a no-op apart from pointer reset.
REQ-028 Storage contents are not cleared by flush or reset; only pointers/count are, and REQ-021 masks stale data.
REQ-029 Outputs in_ready/out_valid are functions of count only; out_pc/out_inst of count and head storage only.

Reset
REQ-030 rst asserted: immediately (asynchronously) head = 0, tail = 0, count = 0, hence in_ready = 1, out_valid = 0, out_inst = NOP_INST, out_pc = 0.
REQ-031 rst asserted mid-operation discards all entries; no push or pop is taken on an edge while rst is high.
REQ-032 After rst deasserts, the first push is accepted on the first rising edge with in_valid high.

Verification
REQ-033 Reset then push pc=0x0/inst=0x00500093 with out_ready=0 -> next cycle count=1, out_valid=1, out_inst=0x00500093, out_pc=0x0.
REQ-034 Push 4 instructions (pc 0x0,0x4,0x8,0xC) with out_ready=0 -> count=4, in_ready=0; 5th push (pc 0x10) ignored; then out_ready=1 for 4 cycles -> pops pc 0x0,0x4,0x8,0xC in order, then out_valid=0, out_inst=0x00000013.
REQ-035 Continuous push and pop for 10 cycles starting at count=2 -> count stays 2, pointers wrap past 3 to 0, PCs emerge in order with exactly 2 cycles queue residency.
REQ-036 count=3, flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_pc=0, pushed instruction absent.
REQ-037 count=4, out_ready=1, in_valid=1 -> one pop only, count=3, the presented instruction is accepted on the following cycle.
REQ-038 count=2, rst pulsed high between clock edges -> outputs at reset values before next edge; after release count=0 and next push appears as the new head.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: small first-word-fall-through FIFO of {pc, inst} pairs
// between fetch and decode, with synchronous flush on redirect.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          pop;

    // Handshake: a transfer happens on a rising edge when valid && ready are both
    // high (and flush is low); ready depends only on occupancy, never on the other side.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Empty queue masks whatever stale entry sits under the head pointer.
    assign out_pc    = out_valid ? mem[head][63:32] : 32'h0;
    assign out_inst  = out_valid ? mem[head][31:0]  : NOP_INST;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {in_pc, in_inst};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_inst_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    inst_fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_ready(out_ready), .count(count)
    );

    // clock/reset block
    always #5 clk = ~clk;

    // reference model: FIFO of {pc, inst}
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            bit do_push;
            bit do_pop;
            do_push = in_valid && (exp_q.size() < DEPTH) && !flush;
            do_pop  = (exp_q.size() != 0) && out_ready && !flush;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (do_pop)  void'(exp_q.pop_front());
                if (do_push) exp_q.push_back({in_pc, in_inst});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process, mid-cycle
    always @(negedge clk) begin
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_pc   = (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0;
        e_inst = (exp_q.size() != 0) ? exp_q[0][31:0]  : NOP;
        chk("model_count", 32'(count), 32'(exp_q.size()));
        chk("model_in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
        chk("model_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("model_out_pc", out_pc, e_pc);
        chk("model_out_inst", out_inst, e_inst);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic r, input logic f);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = r;
        flush     = f;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_inst"}, out_inst, NOP);
        chk({tag, "_out_pc"}, out_pc, 32'h0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;

        // single push; not visible before the edge, visible after
        drive(1, 32'h0, 32'h00500093, 0, 0);
        #1 chk("no_bypass_valid", 32'(out_valid), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("push1_count", 32'(count), 32'd1);
        chk("push1_valid", 32'(out_valid), 32'd1);
        chk("push1_inst", out_inst, 32'h00500093);
        chk("push1_pc", out_pc, 32'h0);
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);

        // fill, overflow attempt, drain
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(4 * i), 32'hA0000013 + 32'(i), 0, 0);
            tick();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(1, 32'h10, 32'hBAD00013, 0, 0);
        tick();
        chk("overflow_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0);
            chk("drain_pc", out_pc, 32'(4 * i));
            tick();
        end
        drive(0, 0, 0, 0, 0);
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_inst", out_inst, NOP);

        // steady push+pop at count 2, pointers wrap
        drive(1, 32'h100, 32'h11100013, 0, 0);
        tick();
        drive(1, 32'h104, 32'h11200013, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h108 + 32'(4 * k), 32'h22000013 + 32'(k), 1, 0);
            chk("stream_pc", out_pc, 32'h100 + 32'(4 * k));
            chk("stream_count", 32'(count), 32'd2);
            tick();
        end
        chk("stream_end_count", 32'(count), 32'd2);

        // flush at count 3 with concurrent push and pop
        drive(1, 32'h180, 32'h33300013, 0, 0);
        tick();
        chk("pre_flush_count", 32'(count), 32'd3);
        drive(1, 32'h190, 32'h44400013, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_pc", out_pc, 32'h0);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("flush_empty_count", 32'(count), 32'd0);
        drive(0, 0, 0, 0, 0);

        // full with push+pop: pop only, presented word accepted next cycle
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h200 + 32'(4 * i), 32'h55000013 + 32'(i), 0, 0);
            tick();
        end
        drive(1, 32'h300, 32'h66600013, 1, 0);
        tick();
        chk("full_pop_count", 32'(count), 32'd3);
        chk("full_pop_head", out_pc, 32'h204);
        drive(1, 32'h300, 32'h66600013, 0, 0);
        tick();
        chk("full_accept_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = (i < 3) ? 32'h204 + 32'(4 * i) : 32'h300;
            drive(0, 0, 0, 1, 0);
            chk("full_drain_pc", out_pc, e);
            tick();
        end
        drive(0, 0, 0, 0, 0);

        // async reset mid-cycle at count 2
        drive(1, 32'h380, 32'h77700013, 0, 0);
        tick();
        drive(1, 32'h384, 32'h77800013, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        #2 rst = 1'b0;
        drive(1, 32'h400, 32'h88800013, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_pc", out_pc, 32'h400);
        chk("post_rst_inst", out_inst, 32'h88800013);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
